// File: rtl/instr_sequencer.sv
// Run/Done initiator: fetches program words, issues each one on DIN with a one-cycle Run pulse,
// and for mvi swaps DIN to the immediate word before waiting for Done.
module instr_sequencer #(
  parameter int         ADDR_W    = 5,
  parameter int         DATA_W    = 16,
  parameter int         PROG_LEN  = 32,
  parameter int         TIMEOUT   = 15,
  parameter logic [8:0] HALT_WORD = 9'h1FF
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Done,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic              Err,
  output logic [ADDR_W-1:0] PC
);

  typedef enum logic [2:0] {IDLE, RD_I, LATCH_I, ISSUE, WAIT_DONE, HALT, ERR} state_t;

  localparam int                  CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W+1:0]   PROG_LEN_X = (ADDR_W + 2)'(PROG_LEN);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                run_q, run_d, halted_q, halted_d, err_q, err_d, mvi_q, mvi_d;
  logic                is_mvi, is_halt;
  logic [ADDR_W-1:0]   pc_inc1, pc_adv;

  function automatic logic [ADDR_W-1:0] pc_add(input logic [ADDR_W-1:0] pc, input logic [1:0] inc);
    logic [ADDR_W+1:0] sum;
    sum = {2'b00, pc} + {{ADDR_W{1'b0}}, inc};
    if (sum >= PROG_LEN_X) sum = sum - PROG_LEN_X;
    return sum[ADDR_W-1:0];
  endfunction

  assign is_mvi  = (mem_data[8:6] == 3'b001);
  assign is_halt = (mem_data[8:0] == HALT_WORD);
  assign pc_inc1 = pc_add(pc_q, 2'd1);
  assign pc_adv  = pc_add(pc_q, mvi_q ? 2'd2 : 2'd1);

  // The immediate address must reach memory in the same cycle the opcode is seen,
  // otherwise the immediate would arrive one cycle after ISSUE needs it.
  assign mem_addr = (state_q == LATCH_I && is_mvi && !is_halt) ? pc_inc1 : addr_q;

  assign DIN    = din_q;
  assign Run    = run_q;
  assign Halted = halted_q;
  assign Err    = err_q;
  assign PC     = pc_q;
  assign Busy   = (state_q == RD_I) || (state_q == LATCH_I) ||
                  (state_q == ISSUE) || (state_q == WAIT_DONE);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    din_d    = din_q;
    cnt_d    = cnt_q;
    run_d    = 1'b0;
    halted_d = halted_q;
    err_d    = err_q;
    mvi_d    = mvi_q;
    unique case (state_q)
      IDLE: begin
        addr_d = pc_q;
        if (Start) state_d = RD_I;
      end
      RD_I: state_d = LATCH_I;
      LATCH_I: begin
        din_d = mem_data;
        if (is_halt) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          run_d   = 1'b1;
          mvi_d   = is_mvi;
          addr_d  = mem_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (mvi_q) din_d = mem_data;
        if (Done) begin
          pc_d    = pc_adv;
          addr_d  = pc_adv;
          state_d = Start ? RD_I : IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // Done takes priority over an expiring timeout in the same cycle.
        if (Done) begin
          pc_d    = pc_adv;
          addr_d  = pc_adv;
          state_d = Start ? RD_I : IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HALT, ERR: state_d = state_q;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      mvi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      mvi_q    <= mvi_d;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: a transaction-level model tracks the expected PC,
// issued word, mvi immediate, Run spacing, timeout and halt behaviour.
module tb_instr_sequencer;

  localparam int         ADDR_W    = 5;
  localparam int         DATA_W    = 16;
  localparam int         PROG_LEN  = 32;
  localparam int         TIMEOUT   = 15;
  localparam logic [8:0] HALT_WORD = 9'h1FF;

  logic              Clock = 1'b0;
  logic              Resetn = 1'b0;
  logic              Start = 1'b0;
  logic              Done = 1'b0;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] DIN;
  logic              Run, Busy, Halted, Err;
  logic [ADDR_W-1:0] PC;

  logic [DATA_W-1:0] prog [PROG_LEN];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_pc   = 0;
  int gap      = 0;

  instr_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROG_LEN(PROG_LEN),
    .TIMEOUT(TIMEOUT), .HALT_WORD(HALT_WORD)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Done(Done),
    .mem_data(mem_data), .mem_addr(mem_addr), .DIN(DIN), .Run(Run),
    .Busy(Busy), .Halted(Halted), .Err(Err), .PC(PC)
  );

  always #5 Clock = ~Clock;

  // synchronous program memory, one cycle read latency
  always @(posedge Clock) mem_data <= prog[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[8:6] == 3'b001) w[7] = 1'b1;
    if (w[8:0] == HALT_WORD) w[0] = 1'b0;
    return w;
  endfunction

  task automatic do_reset();
    Resetn = 1'b0;
    Start  = 1'b0;
    Done   = 1'b0;
    step();
    Resetn = 1'b1;
    exp_pc = 0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_pc"},     32'(PC),       0);
    check_eq({tag, "_addr"},   32'(mem_addr), 0);
    check_eq({tag, "_din"},    32'(DIN),      0);
    check_eq({tag, "_run"},    32'(Run),      0);
    check_eq({tag, "_busy"},   32'(Busy),     0);
    check_eq({tag, "_halted"}, 32'(Halted),   0);
    check_eq({tag, "_err"},    32'(Err),      0);
  endtask

  // Steps until Run is seen (bounded) and checks the number of cycles taken.
  task automatic wait_run(input int exp_gap);
    int i;
    for (i = 1; i <= 40; i++) begin
      step();
      if (Run === 1'b1) break;
    end
    check_eq("run_gap", i, exp_gap);
  endtask

  // Entered in the Run cycle; Done is raised k cycles later (k > TIMEOUT means never).
  task automatic do_instr(input int k, input bit stop, output int next_gap);
    logic [15:0] instr;
    bit          mvi;
    int          imm_pc;
    instr  = prog[exp_pc];
    mvi    = (instr[8:6] == 3'b001);
    imm_pc = (exp_pc + 1) % PROG_LEN;
    check_eq("issue_pc",   32'(PC),   exp_pc);
    check_eq("issue_din",  32'(DIN),  32'(instr));
    check_eq("issue_busy", 32'(Busy), 1);
    for (int off = 0; off <= TIMEOUT; off++) begin
      Done = (off == k);
      step();
      Done = 1'b0;
      if (off == 0) begin
        check_eq("run_pulse", 32'(Run), 0);
        check_eq("din_hold", 32'(DIN), mvi ? 32'(prog[imm_pc]) : 32'(instr));
        if (stop) Start = 1'b0;
      end
      if (off == k) break;
    end
    if (k <= TIMEOUT) begin
      exp_pc = (exp_pc + (mvi ? 2 : 1)) % PROG_LEN;
      check_eq("pc_next",    32'(PC),       exp_pc);
      check_eq("addr_next",  32'(mem_addr), exp_pc);
      check_eq("busy_after", 32'(Busy),     32'(Start));
      check_eq("err_clear",  32'(Err),      0);
      if (stop) begin
        repeat ($urandom_range(1, 4)) step();
        check_eq("park_busy", 32'(Busy), 0);
        check_eq("park_pc",   32'(PC),   exp_pc);
        Start    = 1'b1;
        next_gap = 3;
      end else begin
        next_gap = 2;
      end
    end else begin
      check_eq("timeout_err",  32'(Err),  1);
      check_eq("timeout_busy", 32'(Busy), 0);
      check_eq("timeout_run",  32'(Run),  0);
      check_eq("timeout_pc",   32'(PC),   exp_pc);
      next_gap = 0;
    end
  endtask

  initial begin
    int k, runs;
    bit stop;

    for (int i = 0; i < PROG_LEN; i++) prog[i] = rand_word();
    prog[0]  = 16'h0008;  // mv R1,R0
    prog[3]  = 16'h0050;  // mvi R2
    prog[4]  = 16'h00A5;
    prog[10] = 16'h0040;
    prog[20] = 16'h0078;
    prog[31] = 16'h0040;  // mvi at the last address, immediate wraps to 0

    do_reset();
    check_reset("reset");

    // sequential execution with random Done latency and occasional Start drops
    Start = 1'b1;
    gap   = 3;
    for (int n = 0; n < 40; n++) begin
      wait_run(gap);
      k    = (n == 0) ? 2 : $urandom_range(0, TIMEOUT);
      stop = (n >= 3) && ($urandom_range(0, 3) == 0);
      if (exp_pc == 31) begin
        stop = 1'b1;
        if (k == 0) k = 1;
      end
      if (k == 0) stop = 1'b0;
      do_instr(k, stop, gap);
    end

    // Done never arrives
    wait_run(gap);
    do_instr(TIMEOUT + 1, 1'b0, gap);
    runs = 0;
    for (int i = 0; i < 10; i++) begin
      Start = 1'($urandom);
      step();
      if (Run === 1'b1) runs++;
    end
    check_eq("err_runs",   runs,        0);
    check_eq("err_sticky", 32'(Err),    1);
    do_reset();
    check_reset("err_reset");

    // HALT_WORD at address 2
    prog[2] = 16'hA1FF;
    Start = 1'b1;
    wait_run(3);
    do_instr($urandom_range(0, TIMEOUT), 1'b0, gap);
    wait_run(gap);
    do_instr($urandom_range(0, TIMEOUT), 1'b0, gap);
    step();
    step();
    check_eq("halt_flag", 32'(Halted), 1);
    check_eq("halt_pc",   32'(PC),     2);
    check_eq("halt_din",  32'(DIN),    32'h0000A1FF);
    check_eq("halt_busy", 32'(Busy),   0);
    runs = 0;
    for (int i = 0; i < 12; i++) begin
      Start = 1'($urandom);
      Done  = 1'($urandom);
      step();
      if (Run === 1'b1) runs++;
    end
    Done = 1'b0;
    check_eq("halt_runs",   runs,        0);
    check_eq("halt_sticky", 32'(Halted), 1);
    check_eq("halt_pc2",    32'(PC),     2);

    // reset in the middle of an mvi wait
    do_reset();
    prog[0] = 16'h0040;
    prog[1] = 16'h1234;
    Start = 1'b1;
    wait_run(3);
    step();
    step();
    check_eq("mid_busy", 32'(Busy), 1);
    Resetn = 1'b0;
    step();
    Resetn = 1'b1;
    Start  = 1'b0;
    check_reset("mid_reset");
    Done = 1'b1;
    step();
    Done = 1'b0;
    step();
    check_eq("late_done_pc",   32'(PC),   0);
    check_eq("late_done_busy", 32'(Busy), 0);
    check_eq("late_done_run",  32'(Run),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
